// File: rtl/sdf_bf2_stage.sv
// -----------------------------------------------------------------------------
// sdf_bf2_stage
// Radix-2 single-path delay-feedback (SDF) butterfly stage. It works with an
// external N-deep delay line for each of re and im. Frames are 2N samples long.
//   - Fill half (cnt < N): input samples go into the delay line. The tail of
//     the delay line, which holds the previous frame's differences, is offered
//     as an output with out_diff=1.
//   - Butterfly half (cnt >= N): the stage forms (tail+in)>>>1 and
//     (tail-in)>>>1. The sum goes out with out_diff=0, and the difference
//     goes back into the delay line.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   in_valid, in_sof      : input qualifier, start-of-frame marker
//   in_re, in_im          : input sample (BW+1 bits, signed)
//   sr_out_re, sr_out_im  : delay-line tails (sample pushed N accepts ago)
//   sr_valid              : delay-line shift enable (= in_valid, 0 in reset)
//   sr_in_re, sr_in_im    : delay-line inputs (combinational)
//   out_valid             : registered output qualifier
//   out_re, out_im        : registered butterfly output
//   out_diff              : 1 = difference term, 0 = sum term
//   out_idx               : position within the half-frame (twiddle address)
// -----------------------------------------------------------------------------
module sdf_bf2_stage #(
    parameter int BW = 16,
    parameter int N  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [BW:0]      in_re,
    input  logic signed [BW:0]      in_im,
    input  logic signed [BW:0]      sr_out_re,
    input  logic signed [BW:0]      sr_out_im,
    output logic                    sr_valid,
    output logic signed [BW:0]      sr_in_re,
    output logic signed [BW:0]      sr_in_im,
    output logic                    out_valid,
    output logic signed [BW:0]      out_re,
    output logic signed [BW:0]      out_im,
    output logic                    out_diff,
    output logic [$clog2(N)-1:0]    out_idx
);

    localparam int CW = $clog2(2 * N);
    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * N - 1);

    // The sum is halved with a floor shift at BW+2 bits, so it cannot overflow.
    function automatic logic signed [BW:0] half_sum(input logic signed [BW:0] a,
                                                    input logic signed [BW:0] b);
        logic signed [BW+1:0] s;
        s = {a[BW], a} + {b[BW], b};
        return s[BW+1:1];
    endfunction

    function automatic logic signed [BW:0] half_diff(input logic signed [BW:0] a,
                                                     input logic signed [BW:0] b);
        logic signed [BW+1:0] s;
        s = {a[BW], a} - {b[BW], b};
        return s[BW+1:1];
    endfunction

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   primed_q, primed_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [BW:0]     out_re_q, out_re_d;
    logic signed [BW:0]     out_im_q, out_im_d;
    logic                   out_diff_q, out_diff_d;
    logic [IW-1:0]          out_idx_q, out_idx_d;

    logic                   sof_s;
    logic                   mid_sof_s;
    logic [CW-1:0]          cnt_eff_s;
    logic                   bf_s;
    logic                   primed_eff_s;
    logic                   cand_valid_s;
    logic                   cand_diff_s;
    logic signed [BW:0]     cand_re_s, cand_im_s;

    // An accepted sof makes the sample index 0. A sof in mid-frame also
    // drops primed for this sample, so stale differences are not emitted.
    assign sof_s        = in_valid & in_sof;
    assign mid_sof_s    = sof_s & (cnt_q != {CW{1'b0}});
    assign cnt_eff_s    = sof_s ? {CW{1'b0}} : cnt_q;
    assign bf_s         = cnt_eff_s[CW-1];
    assign primed_eff_s = primed_q & ~mid_sof_s;
    assign cand_valid_s = bf_s | primed_eff_s;
    assign sr_valid     = in_valid & ~reset;

    // Phase routing: pick the delay-line input and the output candidate.
    always_comb begin
        sr_in_re    = in_re;
        sr_in_im    = in_im;
        cand_re_s   = sr_out_re;
        cand_im_s   = sr_out_im;
        cand_diff_s = 1'b1;
        if (bf_s) begin
            sr_in_re    = half_diff(sr_out_re, in_re);
            sr_in_im    = half_diff(sr_out_im, in_im);
            cand_re_s   = half_sum(sr_out_re, in_re);
            cand_im_s   = half_sum(sr_out_im, in_im);
            cand_diff_s = 1'b0;
        end else begin
            sr_in_re    = in_re;
            sr_in_im    = in_im;
            cand_re_s   = sr_out_re;
            cand_im_s   = sr_out_im;
            cand_diff_s = 1'b1;
        end
    end

    // Next state: the counter, primed, and the output register load or hold.
    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_valid_d = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_diff_d  = out_diff_q;
        out_idx_d   = out_idx_q;
        if (in_valid) begin
            cnt_d       = cnt_eff_s + CW'(1);
            primed_d    = (cnt_eff_s == CNT_LAST) ? 1'b1 : primed_eff_s;
            out_valid_d = cand_valid_s;
            if (cand_valid_s) begin
                out_re_d   = cand_re_s;
                out_im_d   = cand_im_s;
                out_diff_d = cand_diff_s;
                // N is a power of two, so the low bits give cnt or cnt-N.
                out_idx_d  = cnt_eff_s[IW-1:0];
            end else begin
                out_re_d   = out_re_q;
                out_im_d   = out_im_q;
                out_diff_d = out_diff_q;
                out_idx_d  = out_idx_q;
            end
        end else begin
            cnt_d       = cnt_q;
            primed_d    = primed_q;
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with a synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= {CW{1'b0}};
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= {(BW+1){1'b0}};
            out_im_q    <= {(BW+1){1'b0}};
            out_diff_q  <= 1'b0;
            out_idx_q   <= {IW{1'b0}};
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_diff_q  <= out_diff_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_diff  = out_diff_q;
    assign out_idx   = out_idx_q;

endmodule
